// File: rtl/jtframe_ps2_pkg.sv
// Shared types and key codes for the PS/2 keyboard decoder.
// Key codes are 9 bits: {E0-prefix flag, scan code set 2 byte}.
package jtframe_ps2_pkg;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Player 1
  localparam logic [8:0] KEY_P1_UP    = 9'h175;
  localparam logic [8:0] KEY_P1_DOWN  = 9'h172;
  localparam logic [8:0] KEY_P1_LEFT  = 9'h16B;
  localparam logic [8:0] KEY_P1_RIGHT = 9'h174;
  localparam logic [8:0] KEY_P1_B1    = 9'h014;
  localparam logic [8:0] KEY_P1_B2    = 9'h011;
  localparam logic [8:0] KEY_P1_B3    = 9'h029;
  localparam logic [8:0] KEY_P1_B4    = 9'h012;
  localparam logic [8:0] KEY_P1_B5    = 9'h01A;
  localparam logic [8:0] KEY_P1_B6    = 9'h022;
  // Player 2
  localparam logic [8:0] KEY_P2_UP    = 9'h02D;
  localparam logic [8:0] KEY_P2_DOWN  = 9'h02B;
  localparam logic [8:0] KEY_P2_LEFT  = 9'h023;
  localparam logic [8:0] KEY_P2_RIGHT = 9'h034;
  localparam logic [8:0] KEY_P2_B1    = 9'h01C;
  localparam logic [8:0] KEY_P2_B2    = 9'h01B;
  localparam logic [8:0] KEY_P2_B3    = 9'h015;
  localparam logic [8:0] KEY_P2_B4    = 9'h01D;
  localparam logic [8:0] KEY_P2_B5    = 9'h024;
  localparam logic [8:0] KEY_P2_B6    = 9'h02C;
  // Player 3
  localparam logic [8:0] KEY_P3_UP    = 9'h043;
  localparam logic [8:0] KEY_P3_DOWN  = 9'h042;
  localparam logic [8:0] KEY_P3_LEFT  = 9'h03B;
  localparam logic [8:0] KEY_P3_RIGHT = 9'h04B;
  localparam logic [8:0] KEY_P3_B1    = 9'h044;
  localparam logic [8:0] KEY_P3_B2    = 9'h04C;
  // Start / coin
  localparam logic [8:0] KEY_START1   = 9'h016;
  localparam logic [8:0] KEY_START2   = 9'h01E;
  localparam logic [8:0] KEY_START3   = 9'h026;
  localparam logic [8:0] KEY_START4   = 9'h025;
  localparam logic [8:0] KEY_COIN1    = 9'h02E;
  localparam logic [8:0] KEY_COIN2    = 9'h036;
  localparam logic [8:0] KEY_COIN3    = 9'h03D;
  localparam logic [8:0] KEY_COIN4    = 9'h03E;
  // System keys
  localparam logic [8:0] KEY_SERVICE  = 9'h046;
  localparam logic [8:0] KEY_TEST     = 9'h006;
  localparam logic [8:0] KEY_RESET    = 9'h004;
  localparam logic [8:0] KEY_PAUSE    = 9'h04D;

  // Odd parity holds when data plus parity bit contain an odd number of ones
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/jtframe_ps2_rx.sv
// PS/2 serial receiver: 2-FF synchronizers, clock debounce filter,
// frame state machine and inactivity timeout. A timeout abort is
// reported through rx_err so the decoder drops any pending prefix.
module jtframe_ps2_rx
  import jtframe_ps2_pkg::*;
#(
  parameter int          FILTER  = 8,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);

  localparam logic [7:0] FILT_LAST = 8'(FILTER - 1);

  logic       clk_meta_r, clk_sync_r, dat_meta_r, dat_sync_r;
  logic       filt_r;
  logic [7:0] flt_cnt_r;
  logic [15:0] tout_r;
  rx_state_t  state_r;
  logic [2:0] bit_cnt_r;
  logic [7:0] shift_r;
  logic       par_r;
  logic       event_s, tout_hit_s;

  // Bring the asynchronous keyboard lines into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_meta_r <= 1'b1; clk_sync_r <= 1'b1;
      dat_meta_r <= 1'b1; dat_sync_r <= 1'b1;
    end else begin
      clk_meta_r <= ps2_clk;  clk_sync_r <= clk_meta_r;
      dat_meta_r <= ps2_data; dat_sync_r <= dat_meta_r;
    end
  end

  // Receive event on the cycle the filtered clock is about to fall; abort when idle too long mid-frame
  always_comb begin
    event_s = 1'b0;
    if ((clk_sync_r != filt_r) && (flt_cnt_r == FILT_LAST)) begin
      event_s = ~clk_sync_r;
    end else begin
      event_s = 1'b0;
    end
    tout_hit_s = (state_r != RX_IDLE) && (tout_r >= TIMEOUT);
  end

  // Filtered clock flips only after FILTER consecutive differing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_r    <= 1'b1;
      flt_cnt_r <= 8'd0;
    end else if (clk_sync_r == filt_r) begin
      flt_cnt_r <= 8'd0;
    end else if (flt_cnt_r == FILT_LAST) begin
      filt_r    <= clk_sync_r;
      flt_cnt_r <= 8'd0;
    end else begin
      flt_cnt_r <= flt_cnt_r + 8'd1;
    end
  end

  // Cycles since the last receive event, saturating at TIMEOUT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tout_r <= 16'd0;
    end else if (event_s) begin
      tout_r <= 16'd0;
    end else if (tout_r < TIMEOUT) begin
      tout_r <= tout_r + 16'd1;
    end
  end

  // Frame state machine with registered byte and one-cycle strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= RX_IDLE;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'd0;
      par_r     <= 1'b0;
      rx_byte   <= 8'd0;
      rx_valid  <= 1'b0;
      rx_err    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      if (tout_hit_s) begin
        state_r <= RX_IDLE;
        rx_err  <= 1'b1;
      end else if (event_s) begin
        case (state_r)
          RX_IDLE: begin
            if (!dat_sync_r) begin
              state_r   <= RX_DATA;
              bit_cnt_r <= 3'd0;
            end
          end
          RX_DATA: begin
            shift_r   <= {dat_sync_r, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) state_r <= RX_PARITY;
          end
          RX_PARITY: begin
            par_r   <= dat_sync_r;
            state_r <= RX_STOP;
          end
          RX_STOP: begin
            rx_byte <= shift_r;
            if (odd_parity_ok(shift_r, par_r) && dat_sync_r) rx_valid <= 1'b1;
            else                                             rx_err   <= 1'b1;
            state_r <= RX_IDLE;
          end
          default: state_r <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/jtframe_ps2keys.sv
// PS/2 keyboard (scan code set 2) to per-player key vectors.
// Define JTFRAME_KEY3P_EN to decode the player 3 key map; otherwise
// key_joy3 is tied to zero and those codes are ignored.
module jtframe_ps2keys
  import jtframe_ps2_pkg::*;
#(
  parameter int          FILTER  = 8,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [9:0] key_joy1,
  output logic [9:0] key_joy2,
  output logic [9:0] key_joy3,
  output logic [3:0] key_start,
  output logic [3:0] key_coin,
  output logic       key_service,
  output logic       key_test,
  output logic       key_pause,
  output logic       key_reset
);

  logic [7:0] rx_byte_s;
  logic       rx_valid_s, rx_err_s;
  logic       ext_r, brk_r;
  logic       make_s;

  jtframe_ps2_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) u_rx (
    .rst      (rst),
    .clk      (clk),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx_byte  (rx_byte_s),
    .rx_valid (rx_valid_s),
    .rx_err   (rx_err_s)
  );

  assign make_s = ~brk_r;

`ifndef JTFRAME_KEY3P_EN
  assign key_joy3 = 10'd0;
`endif

  // Prefix flags and key-state registers; a break clears, a make sets
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_r <= 1'b0; brk_r <= 1'b0;
      key_joy1 <= 10'd0; key_joy2 <= 10'd0;
`ifdef JTFRAME_KEY3P_EN
      key_joy3 <= 10'd0;
`endif
      key_start <= 4'd0; key_coin <= 4'd0;
      key_service <= 1'b0; key_test <= 1'b0;
      key_pause <= 1'b0; key_reset <= 1'b0;
    end else if (rx_err_s) begin
      ext_r <= 1'b0;
      brk_r <= 1'b0;
    end else if (rx_valid_s) begin
      if (rx_byte_s == PS2_EXT) begin
        ext_r <= 1'b1;
      end else if (rx_byte_s == PS2_BRK) begin
        brk_r <= 1'b1;
      end else begin
        ext_r <= 1'b0;
        brk_r <= 1'b0;
        case ({ext_r, rx_byte_s})
          KEY_P1_RIGHT: key_joy1[0] <= make_s;
          KEY_P1_LEFT:  key_joy1[1] <= make_s;
          KEY_P1_DOWN:  key_joy1[2] <= make_s;
          KEY_P1_UP:    key_joy1[3] <= make_s;
          KEY_P1_B1:    key_joy1[4] <= make_s;
          KEY_P1_B2:    key_joy1[5] <= make_s;
          KEY_P1_B3:    key_joy1[6] <= make_s;
          KEY_P1_B4:    key_joy1[7] <= make_s;
          KEY_P1_B5:    key_joy1[8] <= make_s;
          KEY_P1_B6:    key_joy1[9] <= make_s;
          KEY_P2_RIGHT: key_joy2[0] <= make_s;
          KEY_P2_LEFT:  key_joy2[1] <= make_s;
          KEY_P2_DOWN:  key_joy2[2] <= make_s;
          KEY_P2_UP:    key_joy2[3] <= make_s;
          KEY_P2_B1:    key_joy2[4] <= make_s;
          KEY_P2_B2:    key_joy2[5] <= make_s;
          KEY_P2_B3:    key_joy2[6] <= make_s;
          KEY_P2_B4:    key_joy2[7] <= make_s;
          KEY_P2_B5:    key_joy2[8] <= make_s;
          KEY_P2_B6:    key_joy2[9] <= make_s;
`ifdef JTFRAME_KEY3P_EN
          KEY_P3_RIGHT: key_joy3[0] <= make_s;
          KEY_P3_LEFT:  key_joy3[1] <= make_s;
          KEY_P3_DOWN:  key_joy3[2] <= make_s;
          KEY_P3_UP:    key_joy3[3] <= make_s;
          KEY_P3_B1:    key_joy3[4] <= make_s;
          KEY_P3_B2:    key_joy3[5] <= make_s;
`endif
          KEY_START1:   key_start[0] <= make_s;
          KEY_START2:   key_start[1] <= make_s;
          KEY_START3:   key_start[2] <= make_s;
          KEY_START4:   key_start[3] <= make_s;
          KEY_COIN1:    key_coin[0]  <= make_s;
          KEY_COIN2:    key_coin[1]  <= make_s;
          KEY_COIN3:    key_coin[2]  <= make_s;
          KEY_COIN4:    key_coin[3]  <= make_s;
          KEY_SERVICE:  key_service  <= make_s;
          KEY_TEST:     key_test     <= make_s;
          KEY_RESET:    key_reset    <= make_s;
          KEY_PAUSE:    key_pause    <= make_s;
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtframe_ps2keys.sv
// Directed bench for jtframe_ps2keys: table of byte sequences with the
// expected cumulative key state, plus hand-written corner sequences.
module tb_jtframe_ps2keys;

  localparam int          FILTER  = 8;
  localparam logic [15:0] TIMEOUT = 16'd1000;
  localparam int          HALF    = 14;
`ifdef JTFRAME_KEY3P_EN
  localparam bit K3 = 1'b1;
`else
  localparam bit K3 = 1'b0;
`endif

  logic       clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [9:0] key_joy1, key_joy2, key_joy3;
  logic [3:0] key_start, key_coin;
  logic       key_service, key_test, key_pause, key_reset;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          n;
    logic [7:0]  b0, b1, b2;
    logic [9:0]  j1, j2, j3;
    logic [3:0]  st, cn;
    logic        sv, ts, ps, rs;
  } vec_t;

  vec_t tbl[18];
  vec_t cur;

  jtframe_ps2keys #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .rst(rst), .clk(clk), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_joy1(key_joy1), .key_joy2(key_joy2), .key_joy3(key_joy3),
    .key_start(key_start), .key_coin(key_coin), .key_service(key_service),
    .key_test(key_test), .key_pause(key_pause), .key_reset(key_reset)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input int n, input logic [7:0] b0, b1, b2,
                              input logic [9:0] j1, j2, j3, input logic [3:0] st, cn,
                              input logic sv, ts, ps, rs);
    vec_t v;
    v.n = n; v.b0 = b0; v.b1 = b1; v.b2 = b2;
    v.j1 = j1; v.j2 = j2; v.j3 = j3; v.st = st; v.cn = cn;
    v.sv = sv; v.ts = ts; v.ps = ps; v.rs = rs;
    return v;
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input vec_t e);
    check({tag, ".joy1"},    key_joy1, e.j1);
    check({tag, ".joy2"},    key_joy2, e.j2);
    check({tag, ".joy3"},    key_joy3, e.j3);
    check({tag, ".start"},   {6'd0, key_start}, {6'd0, e.st});
    check({tag, ".coin"},    {6'd0, key_coin},  {6'd0, e.cn});
    check({tag, ".service"}, {9'd0, key_service}, {9'd0, e.sv});
    check({tag, ".test"},    {9'd0, key_test},    {9'd0, e.ts});
    check({tag, ".pause"},   {9'd0, key_pause},   {9'd0, e.ps});
    check({tag, ".reset"},   {9'd0, key_reset},   {9'd0, e.rs});
  endtask

  task automatic send_bit(input logic v);
    ps2_data = v;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b1;
  endtask

  // lat=1 checks key_joy1 exactly around the stop-bit event against lat_exp
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit lat, input logic [9:0] lat_exp);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(bad_par ? ^b : ~^b);
    ps2_data = ~bad_stop;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b0;
    if (lat) begin
      repeat (FILTER + 2) @(posedge clk);
      #1 check("latency.before", key_joy1, cur.j1);
      @(posedge clk);
      #1 check("latency.after", key_joy1, lat_exp);
      repeat (HALF - FILTER - 3) @(posedge clk);
    end else begin
      repeat (HALF) @(posedge clk);
    end
    #1 ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 1'b0, 10'd0);
  endtask

  initial begin
    tbl[0]  = mk(1, 8'h16, 8'h00, 8'h00, 10'h000, 10'h008, 10'h000, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(1, 8'h2E, 8'h00, 8'h00, 10'h000, 10'h008, 10'h000, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[2]  = mk(2, 8'hF0, 8'h16, 8'h00, 10'h000, 10'h008, 10'h000, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[3]  = mk(2, 8'h14, 8'h14, 8'h00, 10'h010, 10'h008, 10'h000, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[4]  = mk(2, 8'hF0, 8'h11, 8'h00, 10'h010, 10'h008, 10'h000, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[5]  = mk(2, 8'hE0, 8'h74, 8'h00, 10'h011, 10'h008, 10'h000, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[6]  = mk(1, 8'h34, 8'h00, 8'h00, 10'h011, 10'h009, 10'h000, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[7]  = mk(2, 8'hF0, 8'h2D, 8'h00, 10'h011, 10'h001, 10'h000, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[8]  = mk(1, 8'h43, 8'h00, 8'h00, 10'h011, 10'h001, K3 ? 10'h008 : 10'h000, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[9]  = mk(1, 8'h4C, 8'h00, 8'h00, 10'h011, 10'h001, K3 ? 10'h028 : 10'h000, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[10] = mk(1, 8'h4D, 8'h00, 8'h00, 10'h011, 10'h001, K3 ? 10'h028 : 10'h000, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[11] = mk(1, 8'h46, 8'h00, 8'h00, 10'h011, 10'h001, K3 ? 10'h028 : 10'h000, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[12] = mk(1, 8'h06, 8'h00, 8'h00, 10'h011, 10'h001, K3 ? 10'h028 : 10'h000, 4'b0000, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[13] = mk(1, 8'h04, 8'h00, 8'h00, 10'h011, 10'h001, K3 ? 10'h028 : 10'h000, 4'b0000, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b1);
    tbl[14] = mk(2, 8'hF0, 8'h4D, 8'h00, 10'h011, 10'h001, K3 ? 10'h028 : 10'h000, 4'b0000, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b1);
    tbl[15] = mk(2, 8'hF0, 8'h14, 8'h00, 10'h001, 10'h001, K3 ? 10'h028 : 10'h000, 4'b0000, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b1);
    tbl[16] = mk(2, 8'hE0, 8'h14, 8'h00, 10'h001, 10'h001, K3 ? 10'h028 : 10'h000, 4'b0000, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b1);
    tbl[17] = mk(1, 8'h3E, 8'h00, 8'h00, 10'h001, 10'h001, K3 ? 10'h028 : 10'h000, 4'b0000, 4'b1001, 1'b1, 1'b1, 1'b0, 1'b1);

    // Reset state
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cur = mk(0, 8'h00, 8'h00, 8'h00, 10'h000, 10'h000, 10'h000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    check_all("reset", cur);

    // Unprefixed 75 is unmapped; E0 75 is P1 up with exact two-cycle latency
    send(8'h75);
    check_all("plain75", cur);
    send(8'hE0);
    send_frame(8'h75, 1'b0, 1'b0, 1'b1, 10'h008);
    cur.j1 = 10'h008;
    check_all("ext75", cur);
    send(8'hE0); send(8'hF0); send(8'h75);
    cur.j1 = 10'h000;
    check_all("brk_ext75", cur);

    // Partial frame after a break prefix is abandoned by timeout
    send(8'hF0);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    repeat (int'(TIMEOUT) + 10) @(posedge clk);
    #1;
    send(8'h2D);
    cur.j2 = 10'h008;
    check_all("timeout", cur);

    // Table-driven sequences, each compared against cumulative state
    for (int i = 0; i < 18; i++) begin
      send(tbl[i].b0);
      if (tbl[i].n > 1) send(tbl[i].b1);
      if (tbl[i].n > 2) send(tbl[i].b2);
      cur = tbl[i];
      check_all($sformatf("vec%0d", i), cur);
    end

    // Error byte changes nothing and clears a pending E0
    send(8'hE0);
    send_frame(8'h14, 1'b1, 1'b0, 1'b0, 10'd0);
    check_all("bad_parity", cur);
    send(8'h14);
    cur.j1 = 10'h011;
    check_all("after_err", cur);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0, 10'd0);
    check_all("bad_stop", cur);

    // Short glitches on ps2_clk in idle are ignored
    @(posedge clk); #1 ps2_clk = 1'b0;
    @(posedge clk); #1 ps2_clk = 1'b1;
    repeat (20) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (FILTER - 1) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_all("glitch", cur);
    send(8'hE0); send(8'hF0); send(8'h74);
    cur.j1 = 10'h010;
    check_all("post_glitch", cur);

    // Reset in the middle of a frame, then a normal frame
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cur = mk(0, 8'h00, 8'h00, 8'h00, 10'h000, 10'h000, 10'h000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    check_all("midrst", cur);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send(8'h16);
    cur.st = 4'b0001;
    check_all("after_rst", cur);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jtframe_ps2keys.md
# jtframe_ps2keys

Decodes a PS/2 keyboard (scan code set 2) into the per-player key vectors consumed by the frame input stage. These are `key_joy1..3`, `key_start`, `key_coin`, `key_service`, `key_test`, `key_pause` and `key_reset`. It sits directly upstream of the input merger, which ORs these active-high vectors with board joystick inputs. It comprises a filtered PS/2 serial receiver, a prefix/break-code state machine and a key-state register file.

## Interface
Parameters:
- `FILTER`, 8: consecutive equal samples required before the filtered PS/2 clock level changes (range 2–255).
- `TIMEOUT`, 16'd50000: `clk` cycles without a filtered PS/2 falling edge before a partial frame is abandoned.

Ports:
- `rst`  in  1  asynchronous, active-high reset
- `clk`  in  1  single system clock; all logic on rising edge
- `ps2_clk`  in  1  raw keyboard clock, asynchronous
- `ps2_data`  in  1  raw keyboard data, asynchronous
- `key_joy1`  out  10  P1 bits: [0]right [1]left [2]down [3]up [9:4] buttons 1–6, active high
- `key_joy2`  out  10  P2, same layout
- `key_joy3`  out  10  P3, same layout
- `key_start`  out  4  start buttons 1P–4P
- `key_coin`  out  4  coins 1P–4P
- `key_service`  out  1  service key
- `key_test`  out  1  test key
- `key_pause`  out  1  pause key level (toggle edge detection is done downstream)
- `key_reset`  out  1  reset key level

## Operation
- **Sync:** `ps2_clk` and `ps2_data` each pass through a 2-FF synchronizer. The synced clock feeds the `FILTER` debounce counter. A receive event is a filtered 1→0 transition; synced data is sampled on that event.
- **Receiver FSM:** IDLE → DATA (8 bits, LSB first) → PARITY → STOP → IDLE.
  - IDLE: a sampled 1 (bad start) stays IDLE.
  - Parity is odd over data + parity bit.
  - STOP samples the stop bit. A byte is valid if parity is OK and stop=1, otherwise it is an error.
- **Timeout:** a counter is cleared on each receive event. Reaching `TIMEOUT` outside IDLE forces IDLE, discards the partial byte, and clears the decoder flags.
- **Decoder on a valid byte:**
  - 0xE0 sets `ext`.
  - 0xF0 sets `brk`.
  - Any other byte forms key `{ext, byte}`, sets its bit to `!brk`, then clears `ext` and `brk`.
- **Error byte:** no key change; clears `ext` and `brk`.
- **Unmapped keys:** ignored, flags still cleared.
- **Key map (hex, E = E0-prefixed):**
  - P1: up E75, down E72, left E6B, right E74; buttons 14,11,29,12,1A,22 (Ctrl, Alt, Space, LShift, Z, X).
  - P2: up 2D(R), down 2B(F), left 23(D), right 34(G); buttons 1C,1B,15,1D,24,2C (A, S, Q, W, E, T).
  - P3: up 43(I), down 42(K), left 3B(J), right 4B(L); buttons 44(O), 4C(;); bits [9:6] are 0.
  - start: 16,1E,26,25 (1–4). coin: 2E,36,3D,3E (5–8).
  - service 46(9); test 06(F2); reset 04(F3); pause 4D(P).
- **Repeats:** typematic repeated make codes are idempotent. A break for an unpressed key is a no-op.

## Timing
- **Reset:** all outputs 0; FSM IDLE; `ext`=`brk`=0; filtered clock level 1; timeout counter 0.
- **Filtered edge:** occurs `FILTER`+2 cycles after a clean `ps2_clk` fall.
- **Byte latency:**
  - cycle N: the stop-bit event is sampled.
  - cycle N+1: the registered byte-valid strobe is asserted.
  - cycle N+2: the outputs update.
- **Byte-valid strobe:** exactly one cycle wide; at most one byte is in flight at a time.
- **Reset mid-frame:** returns the block to its reset state immediately; the next frame is received normally from its start bit.
- **Noise:** glitches shorter than `FILTER` cycles produce no event.

## Configuration
- `JTFRAME_KEY3P_EN` defined: the P3 map is decoded as listed above.
- `JTFRAME_KEY3P_EN` undefined: `key_joy3` is constant 0, P3 codes are treated as unmapped, and the I/K/J/L/O/; registers are not built. 4D still drives `key_pause`.

## Structure
- **Package `jtframe_ps2_pkg`:**
  - receiver state enum
  - constants `PS2_EXT`=8'hE0, `PS2_BRK`=8'hF0
  - 9-bit key-code localparams for every mapped key
- **Sub-module `jtframe_ps2_rx`:** synchronizers, filter, FSM and timeout. Outputs `rx_byte[7:0]`, `rx_valid` and `rx_err`.
- **Top:** prefix flags, decode and output registers.

## Test plan
- Send 75 with no prefix, then E0 75 → `key_joy1` unchanged; then `key_joy1[3]`=1 two cycles after the E0 75 stop bit. Then E0 F0 75 → `key_joy1[3]`=0.
- Send 16 then 2E → `key_start`=4'b0001, `key_coin`=4'b0001. Then F0 16 → `key_start`=0, `key_coin` still 0001.
- Send 14 with wrong parity → no output change. The following good 14 sets `key_joy1[4]`=1 (flags cleared by the error).
- Send 3 bits of a frame, then idle `TIMEOUT`+10 cycles, then a clean frame 2D → `key_joy2[3]`=1, no corruption.
- Send 1-cycle and `FILTER`-1-cycle low pulses on `ps2_clk` while in IDLE → FSM stays IDLE, outputs 0.
- With `JTFRAME_KEY3P_EN` undefined, send 43 and 4C → `key_joy3`=0. Send 4D → `key_pause`=1. Assert `rst` mid-frame → all outputs 0 on the following edge.
